// File: rtl/vga_pkg.sv
// Shared 1024x768 @ 60 Hz raster timing constants for the display path.
// Drawing stages import these for screen-edge and blanking decisions.
package vga_pkg;

  localparam int CNT_W = 12;

  localparam int H_ACTIVE = 1024;
  localparam int H_FRONT  = 24;
  localparam int H_SYNC   = 136;
  localparam int H_BACK   = 160;

  localparam int V_ACTIVE = 768;
  localparam int V_FRONT  = 3;
  localparam int V_SYNC   = 6;
  localparam int V_BACK   = 29;

  function automatic int axis_total(input int active, input int front,
                                    input int sync, input int back);
    return active + front + sync + back;
  endfunction

  localparam int H_TOTAL = axis_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = axis_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from vga_timing_gen to the drawing pipeline.
// frame_tick exists only when VGA_TIMING_FRAME_TICK_EN is defined.
interface vga_timing_gen_if;
  import vga_pkg::*;

  logic [CNT_W-1:0] hcount_out;
  logic             hsync_out;
  logic             hblnk_out;
  logic [CNT_W-1:0] vcount_out;
  logic             vsync_out;
  logic             vblnk_out;
`ifdef VGA_TIMING_FRAME_TICK_EN
  logic             frame_tick;
`endif

  modport master (
`ifdef VGA_TIMING_FRAME_TICK_EN
    output frame_tick,
`endif
    output hcount_out, hsync_out, hblnk_out,
    output vcount_out, vsync_out, vblnk_out
  );

  modport slave (
`ifdef VGA_TIMING_FRAME_TICK_EN
    input frame_tick,
`endif
    input hcount_out, hsync_out, hblnk_out,
    input vcount_out, vsync_out, vblnk_out
  );

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with registered blank/sync decode.
// wrap is combinational so the next axis can step on the same edge.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int   ACTIVE      = H_ACTIVE,
  parameter int   FRONT       = H_FRONT,
  parameter int   SYNC        = H_SYNC,
  parameter int   BACK        = H_BACK,
  parameter logic SYNC_ACTIVE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             blnk,
  output logic             sync,
  output logic             wrap
);

  localparam int               TOTAL      = axis_total(ACTIVE, FRONT, SYNC, BACK);
  localparam logic [CNT_W-1:0] LAST       = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] BLNK_START = CNT_W'(ACTIVE);
  localparam logic [CNT_W-1:0] SYNC_START = CNT_W'(ACTIVE + FRONT);
  localparam logic [CNT_W-1:0] SYNC_END   = CNT_W'(ACTIVE + FRONT + SYNC);

  logic [CNT_W-1:0] count_nxt;

  // NOTE: every always_comb output is given a default first, so no path can infer a latch.
  always_comb begin
    wrap      = inc && (count >= LAST);
    count_nxt = count;
    if (wrap) begin
      count_nxt = '0;
    end else if (inc) begin
      count_nxt = count + 1'b1;
    end
  end

  // Flags decode count_nxt so they describe the count registered on the same edge.
  // NOTE: registers use non-blocking assignments so every one samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
      blnk  <= 1'b0;
      sync  <= ~SYNC_ACTIVE;
    end else begin
      count <= count_nxt;
      blnk  <= (count_nxt >= BLNK_START);
      sync  <= ((count_nxt >= SYNC_START) && (count_nxt < SYNC_END)) ? SYNC_ACTIVE
                                                                      : ~SYNC_ACTIVE;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// 1024x768 @ 60 Hz raster timing generator; every output is registered.
// Define VGA_TIMING_FRAME_TICK_EN to add the start-of-vblank frame_tick pulse.
module vga_timing_gen #(
  parameter int   H_ACTIVE    = vga_pkg::H_ACTIVE,
  parameter int   H_FRONT     = vga_pkg::H_FRONT,
  parameter int   H_SYNC      = vga_pkg::H_SYNC,
  parameter int   H_BACK      = vga_pkg::H_BACK,
  parameter int   V_ACTIVE    = vga_pkg::V_ACTIVE,
  parameter int   V_FRONT     = vga_pkg::V_FRONT,
  parameter int   V_SYNC      = vga_pkg::V_SYNC,
  parameter int   V_BACK      = vga_pkg::V_BACK,
  parameter logic SYNC_ACTIVE = 1'b1
) (
  input logic              clk,
  input logic              rst,
  vga_timing_gen_if.master vga
);
  import vga_pkg::*;

  logic [CNT_W-1:0] h_count;
  logic [CNT_W-1:0] v_count;
  logic             h_blnk;
  logic             h_sync;
  logic             h_wrap;
  logic             v_blnk;
  logic             v_sync;
  logic             v_wrap_unused;

  vga_axis_counter #(
    .ACTIVE      (H_ACTIVE),
    .FRONT       (H_FRONT),
    .SYNC        (H_SYNC),
    .BACK        (H_BACK),
    .SYNC_ACTIVE (SYNC_ACTIVE)
  ) u_h_axis (
    .clk   (clk),
    .rst   (rst),
    .inc   (1'b1),
    .count (h_count),
    .blnk  (h_blnk),
    .sync  (h_sync),
    .wrap  (h_wrap)
  );

  // Lines advance only on the edge where the pixel counter wraps.
  vga_axis_counter #(
    .ACTIVE      (V_ACTIVE),
    .FRONT       (V_FRONT),
    .SYNC        (V_SYNC),
    .BACK        (V_BACK),
    .SYNC_ACTIVE (SYNC_ACTIVE)
  ) u_v_axis (
    .clk   (clk),
    .rst   (rst),
    .inc   (h_wrap),
    .count (v_count),
    .blnk  (v_blnk),
    .sync  (v_sync),
    .wrap  (v_wrap_unused)
  );

  assign vga.hcount_out = h_count;
  assign vga.hsync_out  = h_sync;
  assign vga.hblnk_out  = h_blnk;
  assign vga.vcount_out = v_count;
  assign vga.vsync_out  = v_sync;
  assign vga.vblnk_out  = v_blnk;

`ifdef VGA_TIMING_FRAME_TICK_EN
  localparam logic [CNT_W-1:0] TICK_PREV_LINE = CNT_W'(V_ACTIVE - 1);

  logic frame_tick;

  // High with position (0, V_ACTIVE): the line wrap out of the last visible line.
  always_ff @(posedge clk) begin
    if (!rst) begin
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= h_wrap && (v_count == TICK_PREV_LINE);
    end
  end

  assign vga.frame_tick = frame_tick;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: full-size timing for reset/line checks and
// a shrunken raster (16x11) for frame-level checks, plus an inverted-sync copy.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  vga_timing_gen_if if_d ();
  vga_timing_gen_if if_s ();
  vga_timing_gen_if if_n ();

  vga_timing_gen dut_d (
    .clk (clk),
    .rst (rst),
    .vga (if_d)
  );

  // Small raster: H 8+2+3+3=16, V 6+1+2+2=11, frame 176 clks.
  // hblnk h>=8, hsync h 10..12, vblnk v>=6, vsync v 7..8.
  vga_timing_gen #(
    .H_ACTIVE (8), .H_FRONT (2), .H_SYNC (3), .H_BACK (3),
    .V_ACTIVE (6), .V_FRONT (1), .V_SYNC (2), .V_BACK (2),
    .SYNC_ACTIVE (1'b1)
  ) dut_s (
    .clk (clk),
    .rst (rst),
    .vga (if_s)
  );

  vga_timing_gen #(
    .H_ACTIVE (8), .H_FRONT (2), .H_SYNC (3), .H_BACK (3),
    .V_ACTIVE (6), .V_FRONT (1), .V_SYNC (2), .V_BACK (2),
    .SYNC_ACTIVE (1'b0)
  ) dut_n (
    .clk (clk),
    .rst (rst),
    .vga (if_n)
  );

  task automatic check_reset_state(input string tag);
    checks++;
    if (if_d.hcount_out !== 12'd0 || if_d.vcount_out !== 12'd0) begin
      errors++;
      $display("FAIL %s_d_counts: got (%0d,%0d) want (0,0)", tag, if_d.hcount_out, if_d.vcount_out);
    end
    checks++;
    if ({if_d.hblnk_out, if_d.vblnk_out, if_d.hsync_out, if_d.vsync_out} !== 4'b0000) begin
      errors++;
      $display("FAIL %s_d_flags: got hb=%b vb=%b hs=%b vs=%b want 0000", tag,
               if_d.hblnk_out, if_d.vblnk_out, if_d.hsync_out, if_d.vsync_out);
    end
    checks++;
    if (if_s.hcount_out !== 12'd0 || if_s.vcount_out !== 12'd0) begin
      errors++;
      $display("FAIL %s_s_counts: got (%0d,%0d) want (0,0)", tag, if_s.hcount_out, if_s.vcount_out);
    end
    checks++;
    if ({if_n.hblnk_out, if_n.vblnk_out, if_n.hsync_out, if_n.vsync_out} !== 4'b0011) begin
      errors++;
      $display("FAIL %s_n_flags: got hb=%b vb=%b hs=%b vs=%b want 0011", tag,
               if_n.hblnk_out, if_n.vblnk_out, if_n.hsync_out, if_n.vsync_out);
    end
`ifdef VGA_TIMING_FRAME_TICK_EN
    checks++;
    if (if_s.frame_tick !== 1'b0 || if_d.frame_tick !== 1'b0) begin
      errors++;
      $display("FAIL %s_tick: got s=%b d=%b want 0", tag, if_s.frame_tick, if_d.frame_tick);
    end
`endif
  endtask

  task automatic check_release(input string tag);
    rst = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      checks++;
      if (if_d.hcount_out !== 12'(k) || if_d.vcount_out !== 12'd0) begin
        errors++;
        $display("FAIL %s_release_%0d: got (%0d,%0d) want (%0d,0)", tag, k,
                 if_d.hcount_out, if_d.vcount_out, k);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check_reset_state("por");
    check_release("por");
    // Run into mid-line (full size) / mid-frame (small), then reset again.
    repeat (600) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check_reset_state("mid");
    check_release("mid");
  endtask

  task automatic test_line();
    int blnk_rise = -1, blnk_fall = -1, sync_first = -1, sync_last = -1, sync_len = 0;
    int wrap_prev_h = -1, v_at_wrap = -1, bad_step = 0;
    int h, ph;
    logic pb;
    ph = 3;
    pb = 1'b0;
    for (int i = 0; i < 1400; i++) begin
      @(negedge clk);
      h = int'(if_d.hcount_out);
      if (h != 0 && h != ph + 1) bad_step++;
      if (if_d.hblnk_out && !pb && blnk_rise < 0) blnk_rise = h;
      if (!if_d.hblnk_out && pb && blnk_fall < 0) blnk_fall = h;
      if (if_d.hsync_out) begin
        if (sync_first < 0) sync_first = h;
        sync_last = h;
        sync_len++;
      end
      if (h == 0 && wrap_prev_h < 0) begin
        wrap_prev_h = ph;
        v_at_wrap   = int'(if_d.vcount_out);
      end
      pb = if_d.hblnk_out;
      ph = h;
    end
    checks++;
    if (blnk_rise != 1024) begin errors++; $display("FAIL hblnk_rise: got %0d want 1024", blnk_rise); end
    checks++;
    if (blnk_fall != 0) begin errors++; $display("FAIL hblnk_fall: got %0d want 0", blnk_fall); end
    checks++;
    if (sync_first != 1048) begin errors++; $display("FAIL hsync_first: got %0d want 1048", sync_first); end
    checks++;
    if (sync_last != 1183) begin errors++; $display("FAIL hsync_last: got %0d want 1183", sync_last); end
    checks++;
    if (sync_len != 136) begin errors++; $display("FAIL hsync_len: got %0d want 136", sync_len); end
    checks++;
    if (wrap_prev_h != 1343) begin errors++; $display("FAIL h_wrap_from: got %0d want 1343", wrap_prev_h); end
    checks++;
    if (v_at_wrap != 1) begin errors++; $display("FAIL v_at_hwrap: got %0d want 1", v_at_wrap); end
    checks++;
    if (bad_step != 0) begin errors++; $display("FAIL hcount_step: got %0d bad steps want 0", bad_step); end
  endtask

  task automatic test_frame();
    bit found = 0;
    int vb_min = 99, vb_max = -1, vs_min = 99, vs_max = -1, vs_cycles = 0;
    int period = -1, pred_h = -1, pred_v = -1, inv_bad = 0;
    int ticks = 0, tick_bad = 0;
    int h, v, ph, pv;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (if_s.hcount_out == 12'd0 && if_s.vcount_out == 12'd0) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL frame_sync: got no (0,0) within 400 clks want one");
      return;
    end
    ph = 0;
    pv = 0;
    for (int i = 0; i < 352; i++) begin
      if (i > 0) @(negedge clk);
      h = int'(if_s.hcount_out);
      v = int'(if_s.vcount_out);
      if (if_s.vblnk_out) begin
        if (v < vb_min) vb_min = v;
        if (v > vb_max) vb_max = v;
      end
      if (if_s.vsync_out) begin
        if (v < vs_min) vs_min = v;
        if (v > vs_max) vs_max = v;
        vs_cycles++;
      end
      if (i > 0 && h == 0 && v == 0 && period < 0) begin
        period = i;
        pred_h = ph;
        pred_v = pv;
      end
      if (if_n.hsync_out !== ~if_s.hsync_out || if_n.vsync_out !== ~if_s.vsync_out ||
          if_n.hcount_out !== if_s.hcount_out || if_n.vcount_out !== if_s.vcount_out ||
          if_n.hblnk_out !== if_s.hblnk_out || if_n.vblnk_out !== if_s.vblnk_out)
        inv_bad++;
`ifdef VGA_TIMING_FRAME_TICK_EN
      if (if_s.frame_tick === 1'b1) ticks++;
      if (if_s.frame_tick !== ((h == 0 && v == 6) ? 1'b1 : 1'b0)) tick_bad++;
`endif
      ph = h;
      pv = v;
    end
    checks++;
    if (vb_min != 6 || vb_max != 10) begin
      errors++;
      $display("FAIL vblnk_range: got %0d..%0d want 6..10", vb_min, vb_max);
    end
    checks++;
    if (vs_min != 7 || vs_max != 8) begin
      errors++;
      $display("FAIL vsync_range: got %0d..%0d want 7..8", vs_min, vs_max);
    end
    checks++;
    if (vs_cycles != 64) begin errors++; $display("FAIL vsync_cycles: got %0d want 64", vs_cycles); end
    checks++;
    if (period != 176) begin errors++; $display("FAIL frame_period: got %0d want 176", period); end
    checks++;
    if (pred_h != 15 || pred_v != 10) begin
      errors++;
      $display("FAIL frame_wrap_from: got (%0d,%0d) want (15,10)", pred_h, pred_v);
    end
    checks++;
    if (inv_bad != 0) begin errors++; $display("FAIL sync_inverse: got %0d bad clks want 0", inv_bad); end
`ifdef VGA_TIMING_FRAME_TICK_EN
    checks++;
    if (ticks != 2) begin errors++; $display("FAIL frame_tick_count: got %0d want 2", ticks); end
    checks++;
    if (tick_bad != 0) begin errors++; $display("FAIL frame_tick_pos: got %0d bad clks want 0", tick_bad); end
`endif
  endtask

  task automatic test_wrap_reset();
    bit found = 0;
    int eh, ev, bad = 0, v_after_line = -1;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (if_s.hcount_out == 12'd15 && if_s.vcount_out == 12'd10) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL wrap_sync: got no (15,10) within 400 clks want one");
      return;
    end
    rst = 1'b0;
    @(negedge clk);
    check_reset_state("wrap");
    rst = 1'b1;
    eh = 0;
    ev = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (eh == 15) begin
        eh = 0;
        ev = ev + 1;
      end else begin
        eh = eh + 1;
      end
      if (int'(if_s.hcount_out) != eh || int'(if_s.vcount_out) != ev) bad++;
      if (i == 15) v_after_line = int'(if_s.vcount_out);
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL wrap_resume: got %0d bad clks want 0", bad); end
    checks++;
    if (v_after_line != 1) begin
      errors++;
      $display("FAIL wrap_single_vinc: got v=%0d want 1", v_after_line);
    end
  endtask

  initial begin
    test_reset();
    test_line();
    test_frame();
    test_wrap_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates raster timing for the 1024x768 @ 60 Hz display path (65 MHz pixel clock).
- Sits directly upstream of the background-drawing stage and drives its hcount/vcount/hsync/vsync/hblnk/vblnk inputs.
- All outputs are registered; downstream stages pipeline these signals through unchanged.

Parameters:
- H_ACTIVE, 1024, visible pixels per line
- H_FRONT, 24, front-porch pixels
- H_SYNC, 136, hsync width in pixels
- H_BACK, 160, back-porch pixels
- V_ACTIVE, 768, visible lines per frame
- V_FRONT, 3, front-porch lines
- V_SYNC, 6, vsync width in lines
- V_BACK, 29, back-porch lines
- SYNC_ACTIVE, 1'b1, asserted level of hsync_out/vsync_out

Ports:
- clk  in  1  pixel clock, 65 MHz
- rst  in  1  synchronous, active-low reset; 0 = reset asserted
- hcount_out  out  12  horizontal position, 0..H_TOTAL-1
- hsync_out  out  1  horizontal sync
- hblnk_out  out  1  horizontal blanking
- vcount_out  out  12  vertical position, 0..V_TOTAL-1
- vsync_out  out  1  vertical sync
- vblnk_out  out  1  vertical blanking

Behaviour:
- Derived values: H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK = 1344; V_TOTAL = 806.
- Reset: on any rising clk with rst==0:
  - hcount_out=0, vcount_out=0, hblnk_out=0, vblnk_out=0.
  - hsync_out=vsync_out=~SYNC_ACTIVE (deasserted).
  - This is a self-consistent decode of position (0,0).
- Reset can occur mid-line or mid-frame; it takes effect on the next edge with no partial state retained.
- Horizontal counter: increments by 1 every clk. At H_TOTAL-1 it wraps to 0 on the next clk.
- Vertical counter:
  - Increments only on the cycle hcount wraps (H_TOTAL-1 -> 0).
  - When hcount wraps while vcount==V_TOTAL-1, vcount wraps to 0 on that same edge.
- Flags are decoded from the next-count values and registered in the same edge as the counters. The flags therefore always describe the hcount_out/vcount_out presented in the same cycle, with zero skew.
- Flag definitions:
  - hblnk = (hcount >= H_ACTIVE)
  - hsync = SYNC_ACTIVE when H_ACTIVE+H_FRONT <= hcount < H_ACTIVE+H_FRONT+H_SYNC, i.e. 1048..1183, else deasserted
  - vblnk = (vcount >= V_ACTIVE)
  - vsync = SYNC_ACTIVE when 771 <= vcount < 777, else deasserted
- Latency: the first clk after reset release presents hcount_out=1. The frame period is exactly 1344*806 = 1,083,264 clks.
- Width rule: counters are 12 bits. Comparisons are unsigned, and all parameters must give totals < 4096.
- hcount and vcount never exceed H_TOTAL-1 and V_TOTAL-1. No illegal-state recovery is needed beyond the wrap compare, which uses >=, so any out-of-range value wraps to 0.

Optional Feature:
- Macro: VGA_TIMING_FRAME_TICK_EN
- Defined: adds output port frame_tick (1 bit).
  - Registered one-clk pulse, high in the cycle where hcount_out==0 and vcount_out==V_ACTIVE (start of vertical blanking).
  - Used by game logic to update object positions once per frame.
  - Reset value 0.
- Undefined: the port and its logic are absent. All other outputs are bit-identical to the defined build.

Decomposition:
- Shared package vga_pkg holds:
  - the 1024x768 @ 60 timing constants (H_/V_ ACTIVE, FRONT, SYNC, BACK);
  - derived H_TOTAL/V_TOTAL;
  - CNT_W=12.
- Other drawing stages import the same constants, e.g. for the screen-edge lines at 767/1023.
- One sub-module is natural: vga_axis_counter, instantiated twice (horizontal and vertical). Its interface:
  - Parameters: ACTIVE, FRONT, SYNC, BACK, SYNC_ACTIVE.
  - Inputs: clk, rst, inc.
  - Outputs: count, blnk, sync, wrap.
  - Horizontal instance: inc tied to 1. Vertical instance: inc driven by the horizontal wrap.

Test Plan:
- Hold rst=0 for 5 clks with counters mid-frame (e.g. 500,400) -> next output is hcount=0, vcount=0, blnk=0, sync deasserted. After release, hcount reads 1, 2, 3 on successive clks.
- Run one line from (0,0):
  - hblnk rises at hcount=1024 and falls at the wrap to 0;
  - hsync is asserted for hcount 1048..1183 (136 clks);
  - vcount becomes 1 in the same cycle hcount returns to 0.
- Run a full frame:
  - vblnk is high for vcount 768..805;
  - vsync is asserted for vcount 771..776 (6 lines);
  - at (1343,805) the next clk gives (0,0);
  - the period between successive (0,0) is 1,083,264 clks.
- Set SYNC_ACTIVE=0 -> hsync_out/vsync_out are the exact inverse of the default build on every clk; counts and blnk are unchanged.
- Build with VGA_TIMING_FRAME_TICK_EN -> frame_tick is high exactly at (0,768), once per frame, width 1 clk, 0 during and after reset. Build without it -> all remaining outputs match cycle for cycle.
- Assert rst=0 for one clk at (1343,805), during the wrap -> output is (0,0). Counting resumes normally with no double increment of vcount.
